spi_request_arbiter: RTL and testbench
======================================

// Module: spi_request_arbiter
// PURPOSE
//  Shares one spi_master between two frame requesters (e.g. button-driven sending_data and a periodic source).
//  Grants requesters round-robin, latches the winner's word onto the master's data bus, and holds the start
//  strobe until the master responds. It tracks the master's SS_n through the whole frame, enforces an
//  inter-frame gap, and recovers from a stalled master by timeout. Sits between the data sources and spi_master.
// PARAMETERS
//  DATA_W          10     width of one SPI word, matching the master's data bus
//  GAP_CYCLES      16     clk cycles of SS_n-high idle enforced after each frame, min 1
//  TIMEOUT_CYCLES  4096   max clk cycles allowed in each of WAIT_BUSY and WAIT_DONE, min 4
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       asynchronous active-low reset
//  req         in   2       level request per requester; held until ack
//  data0       in   DATA_W  word of requester 0, sampled on grant
//  data1       in   DATA_W  word of requester 1, sampled on grant
//  ack         out  2       1-cycle pulse: word captured, requester may drop req/change data
//  done        out  2       1-cycle pulse to the granted requester when its frame completes (SS_n back high)
//  spi_data    out  DATA_W  word presented to spi_master; stable from LOAD until the next grant
//  spi_start   out  1       data_update level to spi_master; high from START until SS_n seen low
//  spi_ss_n    in   1       SS from spi_master (clk_div domain), low = frame in progress
//  busy        out  1       high in every state except IDLE
//  timeout_err out  1       1-cycle pulse when a wait state exceeds TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset values (rst_n low, async): ack=0, done=0, spi_data=0, spi_start=0, busy=0, timeout_err=0,
//   state=IDLE, last_grant=1 (so requester 0 wins first), counters=0, ss synchroniser=2'b11.
//  spi_ss_n passes through a 2-flop synchroniser (ss_s); all decisions use ss_s, so it adds 2 cycles of latency.
//  FSM states and transitions:
//   IDLE: if req!=0, pick the winner w. If both requesters request, w = ~last_grant. Otherwise w is the single
//    requester. Register spi_data<=data_w, ack[w]<=1, last_grant<=w, go to START.
//    The ack pulse coincides with the first START cycle.
//   START: drive spi_start=1, clear the timeout counter, go to WAIT_BUSY.
//   WAIT_BUSY: spi_start stays 1. If ss_s==0, drop spi_start next cycle and go to WAIT_DONE.
//    Else if the counter reaches TIMEOUT_CYCLES-1: spi_start=0, timeout_err pulse, go to GAP with no done.
//   WAIT_DONE: counter restarts at 0. If ss_s==1: done[last_grant] pulse, go to GAP.
//    Else if the counter reaches TIMEOUT_CYCLES-1: timeout_err pulse, go to GAP with no done.
//   GAP: count GAP_CYCLES cycles, then go to IDLE. Requests arriving during the gap wait; they are not lost.
//  Latency: req in IDLE -> ack is 1 cycle; req -> spi_start high is 2 cycles.
//  Fairness: with both req held continuously, grants strictly alternate 0,1,0,1...
//  req dropped before ack: it is ignored if dropped before the IDLE sampling edge; no retraction after grant.
//  A req still high in the ack cycle is a new request, considered at the next IDLE.
//  ss_s low while in IDLE/GAP (master misbehaving): ignored. The arbiter does not start a frame until GAP expires.
//  Reset mid-frame: all outputs return to reset values immediately; the in-flight frame is abandoned (no done, no err).
//  Counters are sized $clog2(max(GAP_CYCLES,TIMEOUT_CYCLES))+1 and never wrap. They saturate at the exit compare.
// TESTING
//  1. Reset, req=2'b01, data0=10'h2A5, model master pulls SS_n low 8 clk after start for 80 clk -> ack=01 at +1,
//     spi_data=2A5, spi_start high until ss_s low, done=01 once ss_s high, busy low GAP_CYCLES after done.
//  2. req=2'b11 held, data0=1, data1=2 for 4 frames -> spi_data sequence 1,2,1,2; ack pulses 01,10,01,10.
//  3. Master never drops SS_n -> timeout_err pulse exactly TIMEOUT_CYCLES cycles after entering WAIT_BUSY;
//     no done, spi_start=0; a new grant follows after GAP.
//  4. SS_n stuck low 5000 cycles mid-frame -> timeout_err in WAIT_DONE; next frame starts only after SS_n releases and GAP elapses.
//  5. rst_n low for 1 cycle while in WAIT_DONE -> all outputs 0 asynchronously, state IDLE, pending req re-granted from requester 0.
//  6. req1 rises during GAP of a requester-0 frame -> no ack until GAP ends; then ack=10 one cycle after IDLE entry.

Source files
------------

// File: rtl/spi_request_arbiter.sv
// Purpose: shares one spi_master between two frame requesters, round-robin, with SS_n tracking, inter-frame gap and stall timeout.
// Latency: req -> ack 1 cycle, req -> spi_start 2 cycles; SS_n decisions lag the pin by 2 cycles (synchroniser).
// Backpressure: req is level-held until ack; requests seen during a frame or its gap wait in place until IDLE.
module spi_request_arbiter #(
   parameter int DATA_W         = 10,
   parameter int GAP_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [1:0]        i_req,
   input  logic [DATA_W-1:0] i_data0,
   input  logic [DATA_W-1:0] i_data1,
   output logic [1:0]        o_ack,
   output logic [1:0]        o_done,
   output logic [DATA_W-1:0] o_spi_data,
   output logic              o_spi_start,
   input  logic              i_spi_ss_n,
   output logic              o_busy,
   output logic              o_timeout_err
);

   // One counter serves both the gap and the wait-state timeouts, sized for the larger limit.
   localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_t;

   state_t            r_state;
   logic              r_last_grant;
   logic [CNT_W-1:0]  r_cnt;
   logic [1:0]        r_ack;
   logic [1:0]        r_done;
   logic [DATA_W-1:0] r_spi_data;
   logic              r_spi_start;
   logic              r_busy;
   logic              r_timeout_err;
   logic              r_ss_meta;
   logic              r_ss_s;

   logic              w_any_req;
   logic              w_win;
   logic [1:0]        w_win_oh;
   logic [DATA_W-1:0] w_win_data;
   logic [1:0]        w_done_oh;

   // Winner selection: with both requesting, the one not served last wins; otherwise the lone requester.
   always_comb begin
      w_any_req = |i_req;
      w_win     = 1'b0;
      if (i_req == 2'b11) begin
         w_win = ~r_last_grant;
      end else begin
         w_win = i_req[1];
      end
      w_win_oh   = w_win ? 2'b10 : 2'b01;
      w_win_data = w_win ? i_data1 : i_data0;
      w_done_oh  = r_last_grant ? 2'b10 : 2'b01;
   end

   // Bring the master's SS_n (clk_div domain) into i_clk; idle-high so reset looks like "no frame".
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ss_meta <= 1'b1;
         r_ss_s    <= 1'b1;
      end else begin
         r_ss_meta <= i_spi_ss_n;
         r_ss_s    <= r_ss_meta;
      end
   end

   // Arbitration / frame-tracking FSM with all outputs registered; pulses default low each cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_last_grant  <= 1'b1;
         r_cnt         <= '0;
         r_ack         <= 2'b00;
         r_done        <= 2'b00;
         r_spi_data    <= '0;
         r_spi_start   <= 1'b0;
         r_busy        <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_ack         <= 2'b00;
         r_done        <= 2'b00;
         r_timeout_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_spi_data   <= w_win_data;
                  r_ack        <= w_win_oh;
                  r_last_grant <= w_win;
                  r_busy       <= 1'b1;
                  r_state      <= ST_START;
               end
            end
            ST_START: begin
               r_spi_start <= 1'b1;
               r_cnt       <= '0;
               r_state     <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               // Master acknowledges the start by pulling SS_n low; otherwise give up after the timeout.
               if (!r_ss_s) begin
                  r_spi_start <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= ST_WAIT_DONE;
               end else if (r_cnt == TO_LAST) begin
                  r_spi_start   <= 1'b0;
                  r_timeout_err <= 1'b1;
                  r_cnt         <= '0;
                  r_state       <= ST_GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_WAIT_DONE: begin
               // Frame ends when SS_n returns high; a stuck-low SS_n is abandoned without done.
               if (r_ss_s) begin
                  r_done  <= w_done_oh;
                  r_cnt   <= '0;
                  r_state <= ST_GAP;
               end else if (r_cnt == TO_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_cnt         <= '0;
                  r_state       <= ST_GAP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_GAP: begin
               // Enforced idle between frames; requests and SS_n activity are ignored here.
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_spi_start <= 1'b0;
               r_busy      <= 1'b0;
               r_cnt       <= '0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ack         = r_ack;
   assign o_done        = r_done;
   assign o_spi_data    = r_spi_data;
   assign o_spi_start   = r_spi_start;
   assign o_busy        = r_busy;
   assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Bench for spi_request_arbiter: frame-level model checked every cycle plus hand-computed timing checks.
// Latency: drives at negedge, model steps at posedge, compare at negedge.
// Backpressure: a bench master model answers spi_start with a configurable SS_n frame.
module tb_spi_request_arbiter;
   localparam int DW  = 10;
   localparam int GAP = 16;
   localparam int TO  = 4096;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [1:0]    i_req = 2'b00;
   logic [DW-1:0] i_data0 = '0;
   logic [DW-1:0] i_data1 = '0;
   logic          i_spi_ss_n = 1'b1;
   logic [1:0]    o_ack, o_done;
   logic [DW-1:0] o_spi_data;
   logic          o_spi_start, o_busy, o_timeout_err;

   spi_request_arbiter #(.DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_data0(i_data0), .i_data1(i_data1),
      .o_ack(o_ack), .o_done(o_done), .o_spi_data(o_spi_data), .o_spi_start(o_spi_start),
      .i_spi_ss_n(i_spi_ss_n), .o_busy(o_busy), .o_timeout_err(o_timeout_err)
   );

   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   always @(posedge i_clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, want);
      end
   endtask

   // ---------------- model: one frame at a time, expressed as a procedural timeline ----------------
   logic [1:0]    exp_ack = 2'b00, exp_done = 2'b00;
   logic [DW-1:0] exp_data = '0;
   logic          exp_start = 1'b0, exp_busy = 1'b0, exp_err = 1'b0;
   logic [1:0]    m_hist = 2'b11;
   logic          m_last = 1'b1;
   logic          s_ss = 1'b1;
   logic [1:0]    s_req = 2'b00;
   logic [DW-1:0] s_d0 = '0, s_d1 = '0;

   // Advance one clock edge; r=1 means the edge happened in reset and the frame is abandoned.
   task automatic tick(output bit r);
      @(posedge i_clk);
      exp_ack  = 2'b00;
      exp_done = 2'b00;
      exp_err  = 1'b0;
      if (!i_rst_n) begin
         r = 1'b1;
         m_hist = 2'b11;
         m_last = 1'b1;
         exp_data = '0;
         exp_start = 1'b0;
         exp_busy = 1'b0;
         s_req = 2'b00;
      end else begin
         r = 1'b0;
         s_ss = m_hist[1];
         m_hist = {m_hist[0], i_spi_ss_n};
         s_req = i_req;
         s_d0 = i_data0;
         s_d1 = i_data1;
      end
   endtask

   task automatic frame();
      bit r;
      bit w;
      bit to;
      w = (s_req == 2'b11) ? ~m_last : s_req[1];
      m_last = w;
      exp_ack = w ? 2'b10 : 2'b01;
      exp_data = w ? s_d1 : s_d0;
      exp_busy = 1'b1;
      tick(r);
      if (r) return;
      exp_start = 1'b1;
      to = 1'b1;
      for (int k = 1; k <= TO; k++) begin
         tick(r);
         if (r) return;
         if (!s_ss) begin
            to = 1'b0;
            break;
         end
      end
      exp_start = 1'b0;
      if (to) begin
         exp_err = 1'b1;
      end else begin
         to = 1'b1;
         for (int k = 1; k <= TO; k++) begin
            tick(r);
            if (r) return;
            if (s_ss) begin
               to = 1'b0;
               break;
            end
         end
         if (to) exp_err = 1'b1;
         else exp_done = m_last ? 2'b10 : 2'b01;
      end
      for (int k = 1; k <= GAP; k++) begin
         tick(r);
         if (r) return;
      end
      exp_busy = 1'b0;
   endtask

   initial begin : model
      bit r;
      forever begin
         tick(r);
         if (!r && s_req != 2'b00) frame();
      end
   end

   // ---------------- compare + event log ----------------
   int            ack_cyc_q[$];
   logic [1:0]    ack_val_q[$];
   logic [DW-1:0] ack_dat_q[$];
   int            done_cyc_q[$];
   logic [1:0]    done_val_q[$];
   int            err_cyc_q[$];
   int            start_rise_cyc = 0, start_fall_cyc = 0, busy_fall_cyc = 0;
   logic          prev_start = 1'b0, prev_busy = 1'b0;

   always @(negedge i_clk) begin
      if (!i_rst_n) begin
         chk("ack", 32'(o_ack), 32'd0);
         chk("done", 32'(o_done), 32'd0);
         chk("spi_data", 32'(o_spi_data), 32'd0);
         chk("spi_start", 32'(o_spi_start), 32'd0);
         chk("busy", 32'(o_busy), 32'd0);
         chk("timeout_err", 32'(o_timeout_err), 32'd0);
      end else begin
         chk("ack", 32'(o_ack), 32'(exp_ack));
         chk("done", 32'(o_done), 32'(exp_done));
         chk("spi_data", 32'(o_spi_data), 32'(exp_data));
         chk("spi_start", 32'(o_spi_start), 32'(exp_start));
         chk("busy", 32'(o_busy), 32'(exp_busy));
         chk("timeout_err", 32'(o_timeout_err), 32'(exp_err));
      end
      if (o_ack != 2'b00) begin
         ack_cyc_q.push_back(cyc);
         ack_val_q.push_back(o_ack);
         ack_dat_q.push_back(o_spi_data);
      end
      if (o_done != 2'b00) begin
         done_cyc_q.push_back(cyc);
         done_val_q.push_back(o_done);
      end
      if (o_timeout_err) err_cyc_q.push_back(cyc);
      if (o_spi_start && !prev_start) start_rise_cyc = cyc;
      if (!o_spi_start && prev_start) start_fall_cyc = cyc;
      if (!o_busy && prev_busy) busy_fall_cyc = cyc;
      prev_start = o_spi_start;
      prev_busy = o_busy;
   end

   // ---------------- bench SPI master ----------------
   bit m_en = 1'b1;
   int m_delay = 8;
   int m_len = 80;
   int m_cnt = 0;
   bit m_act = 1'b0;

   initial begin : master
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            i_spi_ss_n = 1'b1;
            m_act = 1'b0;
            m_cnt = 0;
         end else if (m_act) begin
            m_cnt++;
            if (m_cnt == m_delay) i_spi_ss_n = 1'b0;
            else if (m_cnt == m_delay + m_len) begin
               i_spi_ss_n = 1'b1;
               m_act = 1'b0;
            end
         end else if (o_spi_start && m_en) begin
            m_act = 1'b1;
            m_cnt = 0;
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic int cnt_of(input int which);
      case (which)
         0: return ack_cyc_q.size();
         1: return done_cyc_q.size();
         default: return err_cyc_q.size();
      endcase
   endfunction

   task automatic wait_cnt(input string nm, input int which, input int target, input int budget);
      int k = 0;
      while (cnt_of(which) < target && k < budget) begin
         @(negedge i_clk);
         #1;
         k++;
      end
      if (cnt_of(which) < target) chk({nm, "_timeout"}, 32'(cnt_of(which)), 32'(target));
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int k = 0;
      while (o_busy && k < budget) begin
         @(negedge i_clk);
         #1;
         k++;
      end
      if (o_busy) chk({nm, "_idle_timeout"}, 32'(o_busy), 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      @(negedge i_clk);
      #2 i_rst_n = 1'b1;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin : main
      int t0, na, nd, ne, a;
      logic [DW-1:0] t2_dat [4];
      logic [1:0]    t2_ack [4];
      t2_dat[0] = 10'd1;   t2_dat[1] = 10'd2;   t2_dat[2] = 10'd1;   t2_dat[3] = 10'd2;
      t2_ack[0] = 2'b01;   t2_ack[1] = 2'b10;   t2_ack[2] = 2'b01;   t2_ack[3] = 2'b10;

      repeat (3) @(negedge i_clk);
      #1;
      chk("rst_ack", 32'(o_ack), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_spi_start", 32'(o_spi_start), 32'd0);
      i_rst_n = 1'b1;

      // 1: single request, normal frame
      @(negedge i_clk); #1;
      i_data0 = 10'h2A5; i_req = 2'b01; t0 = cyc; na = ack_cyc_q.size(); nd = done_cyc_q.size();
      wait_cnt("t1_ack", 0, na + 1, 20);
      i_req = 2'b00;
      wait_cnt("t1_done", 1, nd + 1, 400);
      wait_idle("t1", 100);
      if (ack_cyc_q.size() > na && done_cyc_q.size() > nd) begin
         chk("t1_ack_lat", 32'(ack_cyc_q[na] - t0), 32'd1);
         chk("t1_ack_val", 32'(ack_val_q[na]), 32'h1);
         chk("t1_data", 32'(ack_dat_q[na]), 32'h2A5);
         chk("t1_start_lat", 32'(start_rise_cyc - t0), 32'd2);
         chk("t1_start_width", 32'(start_fall_cyc - start_rise_cyc), 32'd11);
         chk("t1_done_lat", 32'(done_cyc_q[nd] - ack_cyc_q[na]), 32'd92);
         chk("t1_done_val", 32'(done_val_q[nd]), 32'h1);
         chk("t1_busy_tail", 32'(busy_fall_cyc - done_cyc_q[nd]), 32'(GAP));
      end

      // 2: both held, strict alternation starting at requester 0
      pulse_reset();
      @(negedge i_clk); #1;
      i_data0 = 10'd1; i_data1 = 10'd2; i_req = 2'b11;
      na = ack_cyc_q.size(); nd = done_cyc_q.size();
      wait_cnt("t2_ack", 0, na + 4, 2000);
      i_req = 2'b00;
      wait_cnt("t2_done", 1, nd + 4, 400);
      wait_idle("t2", 100);
      for (int i = 0; i < 4; i++) begin
         if (ack_cyc_q.size() > na + i) begin
            chk($sformatf("t2_data%0d", i), 32'(ack_dat_q[na + i]), 32'(t2_dat[i]));
            chk($sformatf("t2_ack%0d", i), 32'(ack_val_q[na + i]), 32'(t2_ack[i]));
         end
      end

      // 3: master never responds -> WAIT_BUSY timeout, then next grant after the gap
      m_en = 1'b0;
      @(negedge i_clk); #1;
      i_data0 = 10'h0F0; i_req = 2'b01;
      na = ack_cyc_q.size(); nd = done_cyc_q.size(); ne = err_cyc_q.size();
      wait_cnt("t3_ack", 0, na + 1, 20);
      i_req = 2'b00;
      wait_cnt("t3_err", 2, ne + 1, TO + 100);
      chk("t3_no_done", 32'(done_cyc_q.size()), 32'(nd));
      chk("t3_spi_start", 32'(o_spi_start), 32'd0);
      m_en = 1'b1;
      i_data1 = 10'h30C; i_req = 2'b10;
      wait_cnt("t3_ack2", 0, na + 2, 100);
      i_req = 2'b00;
      if (ack_cyc_q.size() > na + 1 && err_cyc_q.size() > ne) begin
         chk("t3_err_lat", 32'(err_cyc_q[ne] - ack_cyc_q[na]), 32'(TO + 1));
         chk("t3_regrant_lat", 32'(ack_cyc_q[na + 1] - err_cyc_q[ne]), 32'(GAP + 1));
         chk("t3_regrant_val", 32'(ack_val_q[na + 1]), 32'h2);
      end
      wait_cnt("t3_done", 1, nd + 1, 400);
      wait_idle("t3", 100);

      // 4: SS_n stuck low -> WAIT_DONE timeout; next frame once SS_n is released
      m_len = 5000;
      @(negedge i_clk); #1;
      i_data0 = 10'h11B; i_req = 2'b01;
      na = ack_cyc_q.size(); nd = done_cyc_q.size(); ne = err_cyc_q.size();
      wait_cnt("t4_ack", 0, na + 1, 20);
      i_req = 2'b00;
      wait_cnt("t4_err", 2, ne + 1, TO + 200);
      chk("t4_no_done", 32'(done_cyc_q.size()), 32'(nd));
      if (ack_cyc_q.size() > na && err_cyc_q.size() > ne)
         chk("t4_err_lat", 32'(err_cyc_q[ne] - ack_cyc_q[na]), 32'(TO + 12));
      for (int k = 0; k < 6000 && !i_spi_ss_n; k++) begin
         @(negedge i_clk); #1;
      end
      m_len = 80;
      i_data0 = 10'h2C3; i_req = 2'b01; t0 = cyc;
      wait_cnt("t4_ack2", 0, na + 2, 20);
      i_req = 2'b00;
      wait_cnt("t4_done", 1, nd + 1, 400);
      wait_idle("t4", 100);
      if (ack_cyc_q.size() > na + 1) begin
         chk("t4_ack2_lat", 32'(ack_cyc_q[na + 1] - t0), 32'd1);
         chk("t4_ack2_data", 32'(ack_dat_q[na + 1]), 32'h2C3);
      end

      // 5: reset during WAIT_DONE, pending requests re-granted from requester 0
      @(negedge i_clk); #1;
      i_data0 = 10'h155; i_data1 = 10'h0AA; i_req = 2'b01;
      na = ack_cyc_q.size(); nd = done_cyc_q.size(); ne = err_cyc_q.size();
      wait_cnt("t5_ack", 0, na + 1, 20);
      i_req = 2'b11;
      repeat (40) @(negedge i_clk);
      #2 i_rst_n = 1'b0;
      #1;
      chk("t5_async_ack", 32'(o_ack), 32'd0);
      chk("t5_async_done", 32'(o_done), 32'd0);
      chk("t5_async_data", 32'(o_spi_data), 32'd0);
      chk("t5_async_start", 32'(o_spi_start), 32'd0);
      chk("t5_async_busy", 32'(o_busy), 32'd0);
      chk("t5_async_err", 32'(o_timeout_err), 32'd0);
      @(negedge i_clk);
      #2 i_rst_n = 1'b1;
      t0 = cyc;
      wait_cnt("t5_ack2", 0, na + 2, 20);
      i_req = 2'b00;
      if (ack_cyc_q.size() > na + 1) begin
         chk("t5_regrant_lat", 32'(ack_cyc_q[na + 1] - t0), 32'd1);
         chk("t5_regrant_val", 32'(ack_val_q[na + 1]), 32'h1);
         chk("t5_regrant_data", 32'(ack_dat_q[na + 1]), 32'h155);
      end
      wait_cnt("t5_done", 1, nd + 1, 400);
      wait_idle("t5", 100);
      chk("t5_one_done", 32'(done_cyc_q.size()), 32'(nd + 1));
      chk("t5_no_err", 32'(err_cyc_q.size()), 32'(ne));

      // 6: requester 1 arrives during requester 0's gap
      @(negedge i_clk); #1;
      i_data0 = 10'h3FF; i_req = 2'b01;
      na = ack_cyc_q.size(); nd = done_cyc_q.size();
      wait_cnt("t6_ack", 0, na + 1, 20);
      i_req = 2'b00;
      wait_cnt("t6_done", 1, nd + 1, 400);
      repeat (3) @(negedge i_clk);
      #1;
      i_data1 = 10'h123; i_req = 2'b10;
      wait_cnt("t6_ack2", 0, na + 2, 60);
      i_req = 2'b00;
      if (ack_cyc_q.size() > na + 1 && done_cyc_q.size() > nd) begin
         chk("t6_gap_hold", 32'(ack_cyc_q[na + 1] - done_cyc_q[nd]), 32'(GAP + 1));
         chk("t6_ack_val", 32'(ack_val_q[na + 1]), 32'h2);
         chk("t6_data", 32'(ack_dat_q[na + 1]), 32'h123);
      end
      wait_cnt("t6_done2", 1, nd + 2, 400);
      wait_idle("t6", 100);
      if (done_cyc_q.size() > nd + 1)
         chk("t6_done_val", 32'(done_val_q[nd + 1]), 32'h2);

      repeat (2) @(negedge i_clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
